// File: rtl/spi_master.sv
// SPI mode-0 master: one byte out on mosi, one byte in from miso per transfer.
// Drives sck and an active-low ss; busy covers the whole transfer including the post-frame gap.
module spi_master #(
  parameter int HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       miso,
  output logic       mosi,
  output logic       sck,
  output logic       ss,
  output logic       busy,
  output logic       new_data,
  output logic [7:0] data_out
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [6:0]       r_tx_sh;   // bit 7 goes straight to mosi on acceptance
  logic [7:0]       r_rx_sh;
  logic             r_mosi;
  logic             r_sck;
  logic             r_ss;
  logic             r_busy;
  logic             r_new_data;
  logic [7:0]       r_data_out;

  logic w_phase_end;
  assign w_phase_end = (r_cnt == CNT_LAST);

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register sees pre-edge values of its neighbours (e.g. r_tx_sh[6]
  // is read and shifted on the same edge without a race).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_mosi     <= 1'b0;
      r_sck      <= 1'b0;
      r_ss       <= 1'b1;
      r_busy     <= 1'b0;
      r_new_data <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_new_data <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_tx_sh <= data_in[6:0];
            r_mosi  <= data_in[7];
            r_ss    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end

        SETUP: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_sck   <= 1'b1;
            r_rx_sh <= {r_rx_sh[6:0], miso};
            r_bit   <= '0;
            r_state <= XFER;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        XFER: begin
          if (w_phase_end) begin
            r_cnt <= '0;
            if (r_sck) begin
              r_sck <= 1'b0;
              // Last fall leaves bit0 on mosi through HOLD; no ninth bit.
              if (r_bit == 3'd7) begin
                r_state <= HOLD;
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_mosi  <= r_tx_sh[6];
                r_tx_sh <= {r_tx_sh[5:0], 1'b0};
              end
            end else begin
              r_sck   <= 1'b1;
              r_rx_sh <= {r_rx_sh[6:0], miso};
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (w_phase_end) begin
            r_cnt      <= '0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
            r_data_out <= r_rx_sh;
            r_new_data <= 1'b1;
            r_state    <= GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        GAP: begin
          // ss stays high here so the peer slave can reload its transmit byte.
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_cnt   <= '0;
          r_sck   <= 1'b0;
          r_ss    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mosi     = r_mosi;
  assign sck      = r_sck;
  assign ss       = r_ss;
  assign busy     = r_busy;
  assign new_data = r_new_data;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_spi_master.sv
// Directed plus randomized bench for spi_master at H=4, with loopback,
// stuck-high and behavioural-slave miso sources.
module tb_spi_master;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       miso;
  logic       mosi;
  logic       sck;
  logic       ss;
  logic       busy;
  logic       new_data;
  logic [7:0] data_out;

  int checks   = 0;
  int failures = 0;

  // 0: loopback, 1: stuck high, 2: behavioural slave
  int         miso_mode = 0;
  logic [7:0] exp_prev  = 8'h00;

  // Behavioural slave: loads its byte on ss fall, advances ~3 clk after each sck fall.
  logic [7:0] s_din   = 8'h00;
  logic [7:0] s_rx    = 8'h00;
  logic       s_miso  = 1'b0;
  logic       s_sck_q = 1'b0;
  logic       s_ss_q  = 1'b1;
  int         s_idx   = 7;
  int         s_dly   = 0;

  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : s_miso;

  spi_master #(.HALF_PERIOD(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .miso     (miso),
    .mosi     (mosi),
    .sck      (sck),
    .ss       (ss),
    .busy     (busy),
    .new_data (new_data),
    .data_out (data_out)
  );

  always @(negedge clk) begin
    s_sck_q <= sck;
    s_ss_q  <= ss;
    if (s_ss_q && !ss) begin
      s_idx  <= 7;
      s_miso <= s_din[7];
    end
    if (!s_sck_q && sck) s_rx <= {s_rx[6:0], mosi};
    if (s_sck_q && !sck) begin
      s_dly <= 2;
    end else if (s_dly != 0) begin
      s_dly <= s_dly - 1;
      if (s_dly == 1 && s_idx != 0) begin
        s_miso <= s_din[s_idx-1];
        s_idx  <= s_idx - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer observed from its accepting edge E0 through E0+18H.
  task automatic run_xfer(input logic [7:0] d, input int mode, input logic [7:0] sdin,
                          input bit extra, input bit hold, input logic [7:0] next_d);
    logic [7:0] exp_rx;
    logic [7:0] mosi_bits = 8'h00;
    logic       prev_sck  = 1'b0;
    int rises = 0, high_cyc = 0, nd_cnt = 0, nd_at = 0, busy_low_at = 0, ss_high = 0, viol = 0;

    miso_mode = mode;
    s_din     = sdin;
    data_in   = d;
    start     = 1'b1;
    @(posedge clk); #1;
    check("e0_busy", busy, 1);
    check("e0_ss", ss, 0);
    check("e0_mosi", mosi, d[7]);
    check("dout_held", data_out, exp_prev);
    start = hold;
    if (hold) data_in = next_d;

    for (int c = 1; c <= 18 * H; c++) begin
      @(posedge clk); #1;
      if (!hold) start = extra && (c == 4 || c == 39);
      if (sck && !prev_sck) begin
        check("rise_time", c, H + 2 * rises * H);
        mosi_bits = {mosi_bits[6:0], mosi};
        rises++;
      end
      if (sck) high_cyc++;
      if (sck && ss) viol++;
      if (ss) ss_high++;
      if (new_data) begin
        nd_cnt++;
        nd_at = c;
      end
      if (!busy && busy_low_at == 0) busy_low_at = c;
      prev_sck = sck;
    end

    exp_rx = (mode == 0) ? d : (mode == 1) ? 8'hFF : sdin;
    check("sck_pulses", rises, 8);
    check("sck_high_cycles", high_cyc, 8 * H);
    check("sck_while_ss_high", viol, 0);
    check("mosi_bits", mosi_bits, d);
    check("new_data_count", nd_cnt, 1);
    check("new_data_time", nd_at, 17 * H);
    check("data_out", data_out, exp_rx);
    check("busy_low_time", busy_low_at, 18 * H);
    check("ss_high_tail", ss_high, H + 1);
    check("sck_idle", sck, 0);
    if (mode == 2) check("slave_rx", s_rx, d);
    exp_prev = exp_rx;
  endtask

  initial begin
    int nd_seen;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", ss, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_new_data", new_data, 0);
    check("rst_data_out", data_out, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    run_xfer(8'hA5, 0, 8'h00, 1'b0, 1'b0, 8'h00);
    run_xfer(8'hC3, 2, 8'h3C, 1'b0, 1'b0, 8'h00);
    run_xfer(8'h5C, 0, 8'h00, 1'b1, 1'b0, 8'h00);
    start = 1'b0;
    @(posedge clk); #1;

    run_xfer(8'h01, 0, 8'h00, 1'b0, 1'b1, 8'h80);
    run_xfer(8'h80, 0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Abort mid-transfer: reset sampled on E0+30.
    miso_mode = 0;
    data_in   = 8'h96;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ss", ss, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_new_data", new_data, 0);
    check("abort_data_out", data_out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_prev = 8'h00;
    nd_seen  = 0;
    for (int c = 0; c < 20 * H; c++) begin
      @(posedge clk); #1;
      if (new_data || busy || !ss) nd_seen++;
    end
    check("abort_quiet", nd_seen, 0);

    run_xfer(8'h5A, 0, 8'h00, 1'b0, 1'b0, 8'h00);
    run_xfer(8'h37, 1, 8'h00, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] rd;
      logic [7:0] rs;
      rd = 8'($urandom);
      rs = 8'($urandom);
      run_xfer(rd, int'($urandom_range(0, 2)), rs, 1'b0, 1'b0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
